// File: rtl/apb_pkg.sv
// Shared APB definitions used by the requester, the completer and the benches.
//   apb_cmp_state_t : completer FSM state (idle / access phase)
//   APB_ADDR_W      : default slot-local address width
//   APB_DATA_W      : default data bus width
package apb_pkg;

    typedef enum logic {APB_IDLE, APB_ACCESS} apb_cmp_state_t;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

endpackage

// File: rtl/apb_regfile_mem.sv
// Byte-wide register storage for the APB completer.
// One synchronous write port, one combinational read port, asynchronous clear.
// Ports:
//   PCLK     in  clock, writes on rising edge
//   PRESETn  in  asynchronous active-low clear of every register
//   wr_en    in  write strobe
//   wr_addr  in  write index
//   wr_data  in  write data
//   rd_addr  in  read index
//   rd_data  out read data (combinational)
module apb_regfile_mem
    import apb_pkg::*;
#(
    parameter int DATA_W = APB_DATA_W,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/apb_completer_regfile.sv
// APB completer serving transfers from a local byte-wide register file, with
// programmable wait states and PSLVERR on out-of-range addresses.
// Ports:
//   PCLK     in  clock
//   PRESETn  in  asynchronous active-low reset
//   PSEL     in  completer select
//   PENABLE  in  access-phase qualifier
//   PWRITE   in  1 = write, 0 = read
//   PADDR    in  slot-local transfer address
//   PWDATA   in  write data
//   PRDATA   out read data, loaded on the read setup edge
//   PREADY   out transfer completes on the edge where PSEL&PENABLE&PREADY
//   PSLVERR  out error response, valid only while PREADY=1
module apb_completer_regfile
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_cmp_state_t    state;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic              err_q;

    logic              setup;
    logic              setup_err;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;

    // A setup phase is only recognised from IDLE; a stray PENABLE=1 there is ignored.
    assign setup     = (state == APB_IDLE) && PSEL && !PENABLE;
    assign setup_err = (32'(PADDR) >= 32'(DEPTH));

    assign PREADY  = (state == APB_ACCESS) && (cnt == 4'd0);
    assign PSLVERR = PREADY && err_q;

    // Commit happens on the completing edge, from the latched transfer only.
    assign wr_en = PREADY && PSEL && PENABLE && write_q && !err_q;

    apb_regfile_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .wr_en   (wr_en),
        .wr_addr (addr_q),
        .wr_data (wdata_q),
        .rd_addr (PADDR[IDX_W-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= APB_IDLE;
            cnt     <= 4'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            PRDATA  <= '0;
        end else begin
            case (state)
                APB_IDLE: begin
                    if (setup) begin
                        write_q <= PWRITE;
                        err_q   <= setup_err;
                        cnt     <= 4'(WAIT_STATES);
                        state   <= APB_ACCESS;
                        // Read data is fetched at setup so it is stable for the whole access phase.
                        if (!PWRITE) begin
                            PRDATA <= setup_err ? '0 : rd_data;
                        end
                    end
                end
                APB_ACCESS: begin
                    if (!PSEL) begin
                        state <= APB_IDLE;
                    end else if (PENABLE) begin
                        if (cnt != 4'd0) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            state <= APB_IDLE;
                        end
                    end
                end
                default: state <= APB_IDLE;
            endcase
        end
    end

    // Address and write data are pure datapath: captured at setup, never reset.
    always_ff @(posedge PCLK) begin
        if (setup) begin
            addr_q  <= PADDR[IDX_W-1:0];
            wdata_q <= PWDATA;
        end
    end

endmodule
